// File: rtl/stereo_frame_scheduler.sv
// stereo_frame_scheduler
// Collects one stereo frame (L and R samples) from two Avalon-ST ADC
// streams and runs it through a single shared mono reverb core: L first,
// then R. The wet pair is then presented to the two DAC sinks. In bypass
// mode the dry frame goes straight to the DACs. If the core does not answer
// within TIMEOUT_CYCLES, the dry sample is substituted and a saturating
// counter records the event.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   adc_{l,r}_data/valid/ready        ADC source streams (ready is combinational)
//   dac_{l,r}_data/valid/ready        DAC sink streams
//   core_in_data/chan/valid/ready     request to the reverb core (chan 0 = L, 1 = R)
//   core_out_data/valid/ready         wet result from the reverb core
//   bypass                            sampled when a complete frame is captured
//   busy                              high whenever not in CAPTURE
//   timeout_count                     saturating count of core timeouts
module stereo_frame_scheduler #(
   parameter int DATA_W         = 24,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] adc_l_data,
   input  logic              adc_l_valid,
   output logic              adc_l_ready,
   input  logic [DATA_W-1:0] adc_r_data,
   input  logic              adc_r_valid,
   output logic              adc_r_ready,
   output logic [DATA_W-1:0] dac_l_data,
   output logic              dac_l_valid,
   input  logic              dac_l_ready,
   output logic [DATA_W-1:0] dac_r_data,
   output logic              dac_r_valid,
   input  logic              dac_r_ready,
   output logic [DATA_W-1:0] core_in_data,
   output logic              core_in_chan,
   output logic              core_in_valid,
   input  logic              core_in_ready,
   input  logic [DATA_W-1:0] core_out_data,
   input  logic              core_out_valid,
   output logic              core_out_ready,
   input  logic              bypass,
   output logic              busy,
   output logic [CNT_W-1:0]  timeout_count
);

   localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_CAPTURE = 3'd0,
      ST_SEND_L  = 3'd1,
      ST_WAIT_L  = 3'd2,
      ST_SEND_R  = 3'd3,
      ST_WAIT_R  = 3'd4,
      ST_OUTPUT  = 3'd5
   } state_t;

   state_t              state_r, state_s;
   logic                have_l_r, have_r_r, have_l_s, have_r_s;
   logic [DATA_W-1:0]   dry_l_r, dry_r_r, dry_l_s, dry_r_s;
   logic [DATA_W-1:0]   out_l_r, out_r_r, out_l_s, out_r_s;
   logic [TCNT_W-1:0]   tcnt_r, tcnt_s;
   logic [CNT_W-1:0]    timeout_count_r, timeout_count_s;
   logic                dac_l_valid_r, dac_r_valid_r, dac_l_valid_s, dac_r_valid_s;
   logic                l_sent_r, r_sent_r, l_sent_s, r_sent_s;
   logic                core_in_valid_r, core_in_valid_s;
   logic [DATA_W-1:0]   core_in_data_r, core_in_data_s;
   logic                core_in_chan_r, core_in_chan_s;
   logic                core_out_ready_r, core_out_ready_s;
   logic                busy_r, busy_s;
   logic                tmo_hit_s;

   logic adc_l_fire_s, adc_r_fire_s, core_in_fire_s, core_out_fire_s;
   logic dac_l_fire_s, dac_r_fire_s, tmo_s, in_wait_s;

   assign adc_l_ready     = (state_r == ST_CAPTURE) && !have_l_r;
   assign adc_r_ready     = (state_r == ST_CAPTURE) && !have_r_r;
   assign adc_l_fire_s    = adc_l_valid && adc_l_ready;
   assign adc_r_fire_s    = adc_r_valid && adc_r_ready;
   assign core_in_fire_s  = core_in_valid_r && core_in_ready;
   // core_out_ready_r is high exactly while in a WAIT state, so stray results elsewhere never fire
   assign core_out_fire_s = core_out_valid && core_out_ready_r;
   assign dac_l_fire_s    = dac_l_valid_r && dac_l_ready;
   assign dac_r_fire_s    = dac_r_valid_r && dac_r_ready;
   assign in_wait_s       = (state_r == ST_WAIT_L) || (state_r == ST_WAIT_R);
   assign tmo_s           = (tcnt_r == TCNT_LAST);

   assign dac_l_data      = out_l_r;
   assign dac_r_data      = out_r_r;
   assign dac_l_valid     = dac_l_valid_r;
   assign dac_r_valid     = dac_r_valid_r;
   assign core_in_data    = core_in_data_r;
   assign core_in_chan    = core_in_chan_r;
   assign core_in_valid   = core_in_valid_r;
   assign core_out_ready  = core_out_ready_r;
   assign busy            = busy_r;
   assign timeout_count   = timeout_count_r;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_CAPTURE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_CAPTURE: if (have_l_r && have_r_r) state_s = bypass ? ST_OUTPUT : ST_SEND_L;
                     else                      state_s = ST_CAPTURE;
         ST_SEND_L:  if (core_in_fire_s)       state_s = ST_WAIT_L;
                     else                      state_s = ST_SEND_L;
         ST_WAIT_L:  if (core_out_fire_s || tmo_s) state_s = ST_SEND_R;
                     else                          state_s = ST_WAIT_L;
         ST_SEND_R:  if (core_in_fire_s)       state_s = ST_WAIT_R;
                     else                      state_s = ST_SEND_R;
         ST_WAIT_R:  if (core_out_fire_s || tmo_s) state_s = ST_OUTPUT;
                     else                          state_s = ST_WAIT_R;
         // A side that already handshook counts as done; both may finish on the same edge
         ST_OUTPUT:  if ((l_sent_r || dac_l_fire_s) && (r_sent_r || dac_r_fire_s)) state_s = ST_CAPTURE;
                     else                                                          state_s = ST_OUTPUT;
         default:    state_s = ST_CAPTURE;
      endcase
   end

   // Output and datapath next values (all outputs except adc ready are registered)
   always_comb begin
      tmo_hit_s = 1'b0;
      out_l_s   = out_l_r;
      out_r_s   = out_r_r;

      if ((state_r == ST_OUTPUT) && (state_s == ST_CAPTURE)) begin
         have_l_s = 1'b0;
         have_r_s = 1'b0;
      end else begin
         have_l_s = have_l_r || adc_l_fire_s;
         have_r_s = have_r_r || adc_r_fire_s;
      end

      if (adc_l_fire_s) dry_l_s = adc_l_data;
      else              dry_l_s = dry_l_r;
      if (adc_r_fire_s) dry_r_s = adc_r_data;
      else              dry_r_s = dry_r_r;

      // Core data wins over a coinciding timeout
      case (state_r)
         ST_CAPTURE: begin
            if (state_s == ST_OUTPUT) begin
               out_l_s = dry_l_r;
               out_r_s = dry_r_r;
            end else begin
               out_l_s = out_l_r;
               out_r_s = out_r_r;
            end
         end
         ST_WAIT_L: begin
            if (core_out_fire_s) begin
               out_l_s = core_out_data;
            end else if (tmo_s) begin
               out_l_s   = dry_l_r;
               tmo_hit_s = 1'b1;
            end else begin
               out_l_s = out_l_r;
            end
         end
         ST_WAIT_R: begin
            if (core_out_fire_s) begin
               out_r_s = core_out_data;
            end else if (tmo_s) begin
               out_r_s   = dry_r_r;
               tmo_hit_s = 1'b1;
            end else begin
               out_r_s = out_r_r;
            end
         end
         default: begin
            out_l_s = out_l_r;
            out_r_s = out_r_r;
         end
      endcase

      if (tmo_hit_s && (timeout_count_r != {CNT_W{1'b1}})) timeout_count_s = timeout_count_r + CNT_W'(1'b1);
      else                                                 timeout_count_s = timeout_count_r;

      // tcnt sits at zero during SEND so each WAIT starts counting from zero
      if (in_wait_s) tcnt_s = tcnt_r + TCNT_W'(1'b1);
      else           tcnt_s = {TCNT_W{1'b0}};

      // DAC valids rise one cycle after entering OUTPUT and drop after their own handshake
      if (state_r == ST_OUTPUT) begin
         dac_l_valid_s = dac_l_valid_r ? !dac_l_ready : !l_sent_r;
         dac_r_valid_s = dac_r_valid_r ? !dac_r_ready : !r_sent_r;
         if (state_s == ST_CAPTURE) begin
            l_sent_s = 1'b0;
            r_sent_s = 1'b0;
         end else begin
            l_sent_s = l_sent_r || dac_l_fire_s;
            r_sent_s = r_sent_r || dac_r_fire_s;
         end
      end else begin
         dac_l_valid_s = 1'b0;
         dac_r_valid_s = 1'b0;
         l_sent_s      = 1'b0;
         r_sent_s      = 1'b0;
      end

      core_in_valid_s  = (state_s == ST_SEND_L) || (state_s == ST_SEND_R);
      core_in_chan_s   = (state_s == ST_SEND_R);
      core_in_data_s   = (state_s == ST_SEND_R) ? dry_r_r : dry_l_r;
      core_out_ready_s = (state_s == ST_WAIT_L) || (state_s == ST_WAIT_R);
      busy_s           = (state_s != ST_CAPTURE);
   end

   // Output and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         have_l_r         <= 1'b0;
         have_r_r         <= 1'b0;
         dry_l_r          <= {DATA_W{1'b0}};
         dry_r_r          <= {DATA_W{1'b0}};
         out_l_r          <= {DATA_W{1'b0}};
         out_r_r          <= {DATA_W{1'b0}};
         tcnt_r           <= {TCNT_W{1'b0}};
         timeout_count_r  <= {CNT_W{1'b0}};
         dac_l_valid_r    <= 1'b0;
         dac_r_valid_r    <= 1'b0;
         l_sent_r         <= 1'b0;
         r_sent_r         <= 1'b0;
         core_in_valid_r  <= 1'b0;
         core_in_data_r   <= {DATA_W{1'b0}};
         core_in_chan_r   <= 1'b0;
         core_out_ready_r <= 1'b0;
         busy_r           <= 1'b0;
      end else begin
         have_l_r         <= have_l_s;
         have_r_r         <= have_r_s;
         dry_l_r          <= dry_l_s;
         dry_r_r          <= dry_r_s;
         out_l_r          <= out_l_s;
         out_r_r          <= out_r_s;
         tcnt_r           <= tcnt_s;
         timeout_count_r  <= timeout_count_s;
         dac_l_valid_r    <= dac_l_valid_s;
         dac_r_valid_r    <= dac_r_valid_s;
         l_sent_r         <= l_sent_s;
         r_sent_r         <= r_sent_s;
         core_in_valid_r  <= core_in_valid_s;
         core_in_data_r   <= core_in_data_s;
         core_in_chan_r   <= core_in_chan_s;
         core_out_ready_r <= core_out_ready_s;
         busy_r           <= busy_s;
      end
   end

endmodule

// File: tb/tb_stereo_frame_scheduler.sv
// Self-checking bench for stereo_frame_scheduler (TIMEOUT_CYCLES = 8).
// A behavioural reverb core echoes data XOR 0xFFFFFF after a programmable
// latency; DAC and core-request expectations are queued when stimulus is
// driven and compared when the DUT produces them.
module tb_stereo_frame_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [23:0] adc_l_data, adc_r_data;
   logic        adc_l_valid, adc_r_valid, adc_l_ready, adc_r_ready;
   logic [23:0] dac_l_data, dac_r_data;
   logic        dac_l_valid, dac_r_valid, dac_l_ready, dac_r_ready;
   logic [23:0] core_in_data, core_out_data;
   logic        core_in_chan, core_in_valid, core_in_ready;
   logic        core_out_valid, core_out_ready;
   logic        bypass, busy;
   logic [15:0] timeout_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [23:0] exp_l[$];
   logic [23:0] exp_r[$];
   logic [24:0] exp_core[$];

   // written only by the core model / monitor
   logic [24:0] obs_core_log [0:63];
   int          obs_wr = 0;
   int          run_log [0:63];
   int          run_wr = 0;
   int          stale_done = 0;
   int          stale_ready_seen = 0;
   // written only by the main sequence
   int          obs_rd = 0;
   int          run_rd = 0;
   int          stale_req = 0;
   int          core_mode = 0;
   int          core_lat = 3;

   always #5 clk = ~clk;

   stereo_frame_scheduler #(.DATA_W(24), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .adc_l_data(adc_l_data), .adc_l_valid(adc_l_valid), .adc_l_ready(adc_l_ready),
      .adc_r_data(adc_r_data), .adc_r_valid(adc_r_valid), .adc_r_ready(adc_r_ready),
      .dac_l_data(dac_l_data), .dac_l_valid(dac_l_valid), .dac_l_ready(dac_l_ready),
      .dac_r_data(dac_r_data), .dac_r_valid(dac_r_valid), .dac_r_ready(dac_r_ready),
      .core_in_data(core_in_data), .core_in_chan(core_in_chan), .core_in_valid(core_in_valid),
      .core_in_ready(core_in_ready), .core_out_data(core_out_data), .core_out_valid(core_out_valid),
      .core_out_ready(core_out_ready), .bypass(bypass), .busy(busy), .timeout_count(timeout_count)
   );

   // Behavioural reverb core: logs every request, optionally answers, and emits stale pulses on demand
   initial begin : core_model
      logic [23:0] req_d;
      int          n;
      bit          got;
      core_out_valid = 1'b0;
      core_out_data  = 24'h000000;
      forever begin
         @(negedge clk);
         if (reset_n && core_in_valid && core_in_ready) begin
            if (obs_wr < 64) obs_core_log[obs_wr] = {core_in_chan, core_in_data};
            obs_wr++;
            core_out_valid = 1'b0;
            if (core_mode != 0) begin
               req_d = core_in_data;
               @(posedge clk);
               repeat (core_lat) @(posedge clk);
               #1;
               core_out_valid = 1'b1;
               core_out_data  = req_d ^ 24'hFFFFFF;
               got = 1'b0;
               n = 0;
               while (!got && n < 64) begin
                  @(negedge clk);
                  got = core_out_ready;
                  n++;
               end
               @(posedge clk);
               #1;
               core_out_valid = 1'b0;
            end
         end else if (stale_done < stale_req) begin
            core_out_valid = 1'b1;
            core_out_data  = 24'hBAD0BA;
            if (core_out_ready) stale_ready_seen++;
            stale_done++;
         end else begin
            core_out_valid = 1'b0;
         end
      end
   end

   // Records the length of every core_out_ready-high run
   initial begin : ready_mon
      int run;
      run = 0;
      forever begin
         @(negedge clk);
         if (core_out_ready) run++;
         else if (run > 0) begin
            if (run_wr < 64) run_log[run_wr] = run;
            run_wr++;
            run = 0;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1, "watchdog");
   end

   task automatic adc_push(input bit chan, input logic [23:0] d);
      int n;
      bit ok;
      if (!chan) begin adc_l_data = d; adc_l_valid = 1'b1; end
      else       begin adc_r_data = d; adc_r_valid = 1'b1; end
      n = 0;
      do begin
         @(negedge clk);
         ok = chan ? adc_r_ready : adc_l_ready;
         n++;
      end while (!ok && n < 300);
      n_checks++;
      if (!ok) begin
         $display("FAIL adc_accept ch%0d: ready got 0, required 1 within 300 cycles", chan);
         n_fail++;
      end
      @(posedge clk);
      #1;
      adc_l_valid = 1'b0;
      adc_r_valid = 1'b0;
   endtask

   task automatic drain(input int l_delay, input int r_delay);
      int n;
      bit l_got, r_got;
      logic [23:0] e;
      n = 0;
      do begin @(negedge clk); n++; end while (!(dac_l_valid && dac_r_valid) && n < 400);
      n_checks++;
      if (!(dac_l_valid && dac_r_valid)) begin
         $display("FAIL dac_valid_wait: got l=%b r=%b, required both 1", dac_l_valid, dac_r_valid);
         n_fail++;
      end
      l_got = 1'b0;
      r_got = 1'b0;
      for (int c = 0; c < 400 && !(l_got && r_got); c++) begin
         if (c > 0) @(negedge clk);
         dac_l_ready = (c >= l_delay);
         dac_r_ready = (c >= r_delay);
         n_checks++;
         if (adc_l_ready !== 1'b0 || adc_r_ready !== 1'b0) begin
            $display("FAIL adc_ready_in_output: got l=%b r=%b, required 0", adc_l_ready, adc_r_ready);
            n_fail++;
         end
         n_checks++;
         if (busy !== 1'b1) begin
            $display("FAIL busy_in_output: got %b, required 1", busy);
            n_fail++;
         end
         if (l_got) begin
            n_checks++;
            if (dac_l_valid !== 1'b0) begin
               $display("FAIL dac_l_drop: got valid %b, required 0 after handshake", dac_l_valid);
               n_fail++;
            end
         end else if (dac_l_valid && dac_l_ready) begin
            if (exp_l.size() > 0) e = exp_l.pop_front(); else e = 'x;
            n_checks++;
            if (dac_l_data !== e) begin
               $display("FAIL dac_l_data: got %h, required %h", dac_l_data, e);
               n_fail++;
            end
            l_got = 1'b1;
         end
         if (r_got) begin
            n_checks++;
            if (dac_r_valid !== 1'b0) begin
               $display("FAIL dac_r_drop: got valid %b, required 0 after handshake", dac_r_valid);
               n_fail++;
            end
         end else if (dac_r_valid && dac_r_ready) begin
            if (exp_r.size() > 0) e = exp_r.pop_front(); else e = 'x;
            n_checks++;
            if (dac_r_data !== e) begin
               $display("FAIL dac_r_data: got %h, required %h", dac_r_data, e);
               n_fail++;
            end
            r_got = 1'b1;
         end
      end
      n_checks++;
      if (!(l_got && r_got)) begin
         $display("FAIL dac_handshake: got l=%b r=%b, required both done", l_got, r_got);
         n_fail++;
      end
      @(posedge clk);
      #1;
      dac_l_ready = 1'b0;
      dac_r_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || dac_l_valid !== 1'b0 || dac_r_valid !== 1'b0 || adc_l_ready !== 1'b1) begin
         $display("FAIL frame_end: got busy=%b vl=%b vr=%b adc_l_ready=%b, required 0 0 0 1",
                  busy, dac_l_valid, dac_r_valid, adc_l_ready);
         n_fail++;
      end
   endtask

   task automatic core_log_compare(input string tag);
      logic [24:0] ec;
      while (exp_core.size() > 0) begin
         ec = exp_core.pop_front();
         n_checks++;
         if (obs_rd >= obs_wr) begin
            $display("FAIL %s core_req: got none, required chan=%0d data=%h", tag, ec[24], ec[23:0]);
            n_fail++;
         end else begin
            if (obs_core_log[obs_rd] !== ec) begin
               $display("FAIL %s core_req: got %h, required %h", tag, obs_core_log[obs_rd], ec);
               n_fail++;
            end
            obs_rd++;
         end
      end
      n_checks++;
      if (obs_rd != obs_wr) begin
         $display("FAIL %s core_req_extra: got %0d requests, required %0d", tag, obs_wr, obs_rd);
         n_fail++;
         obs_rd = obs_wr;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({dac_l_valid, dac_r_valid, core_in_valid, core_out_ready, busy} !== 5'b00000) begin
         $display("FAIL reset_valids: got %b, required 00000",
                  {dac_l_valid, dac_r_valid, core_in_valid, core_out_ready, busy});
         n_fail++;
      end
      n_checks++;
      if (timeout_count !== 16'h0000 || dac_l_data !== 24'h0 || dac_r_data !== 24'h0 || core_in_data !== 24'h0) begin
         $display("FAIL reset_data: got tc=%h l=%h r=%h core=%h, required zeros",
                  timeout_count, dac_l_data, dac_r_data, core_in_data);
         n_fail++;
      end
      n_checks++;
      if (adc_l_ready !== 1'b1 || adc_r_ready !== 1'b1) begin
         $display("FAIL reset_adc_ready: got l=%b r=%b, required 1 1", adc_l_ready, adc_r_ready);
         n_fail++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || adc_l_ready !== 1'b1) begin
         $display("FAIL post_reset: got busy=%b adc_l_ready=%b, required 0 1", busy, adc_l_ready);
         n_fail++;
      end
   endtask

   task automatic test_bypass();
      int base;
      base = obs_wr;
      obs_rd = obs_wr;
      bypass = 1'b1;
      exp_l.push_back(24'h123456);
      exp_r.push_back(24'hABCDEF);
      adc_push(1'b0, 24'h123456);
      adc_push(1'b1, 24'hABCDEF);
      // now just after edge k (R accept)
      n_checks++;
      if (dac_l_valid !== 1'b0 || dac_r_valid !== 1'b0) begin
         $display("FAIL bypass_lat_k: got %b%b, required 00", dac_l_valid, dac_r_valid);
         n_fail++;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (dac_l_valid !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL bypass_lat_k1: got valid=%b busy=%b, required 0 1", dac_l_valid, busy);
         n_fail++;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (dac_l_valid !== 1'b1 || dac_r_valid !== 1'b1) begin
         $display("FAIL bypass_lat_k2: got %b%b, required 11", dac_l_valid, dac_r_valid);
         n_fail++;
      end
      bypass = 1'b0;
      drain(0, 0);
      n_checks++;
      if (obs_wr != base) begin
         $display("FAIL bypass_no_core: got %0d core requests, required 0", obs_wr - base);
         n_fail++;
         obs_rd = obs_wr;
      end
   endtask

   task automatic test_core_echo();
      core_mode = 1;
      core_lat  = 3;
      bypass    = 1'b0;
      exp_core.push_back({1'b0, 24'h123456});
      exp_core.push_back({1'b1, 24'hABCDEF});
      exp_l.push_back(24'hEDCBA9);
      exp_r.push_back(24'h543210);
      adc_push(1'b0, 24'h123456);
      adc_push(1'b1, 24'hABCDEF);
      n_checks++;
      if (core_in_valid !== 1'b0) begin
         $display("FAIL core_lat_k: got %b, required 0", core_in_valid);
         n_fail++;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (core_in_valid !== 1'b1 || core_in_chan !== 1'b0 || core_in_data !== 24'h123456) begin
         $display("FAIL core_lat_k1: got v=%b ch=%b d=%h, required 1 0 123456",
                  core_in_valid, core_in_chan, core_in_data);
         n_fail++;
      end
      drain(0, 0);
      core_log_compare("echo");
      n_checks++;
      if (timeout_count !== 16'd0) begin
         $display("FAIL echo_timeout_count: got %0d, required 0", timeout_count);
         n_fail++;
      end
   endtask

   task automatic test_timeout();
      core_mode = 0;
      run_rd = run_wr;
      exp_core.push_back({1'b0, 24'h0F0F0F});
      exp_core.push_back({1'b1, 24'h5A5A5A});
      exp_l.push_back(24'h0F0F0F);
      exp_r.push_back(24'h5A5A5A);
      adc_push(1'b0, 24'h0F0F0F);
      adc_push(1'b1, 24'h5A5A5A);
      drain(0, 0);
      core_log_compare("timeout");
      n_checks++;
      if (timeout_count !== 16'd2) begin
         $display("FAIL timeout_count: got %0d, required 2", timeout_count);
         n_fail++;
      end
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (run_rd >= run_wr || run_log[run_rd] != 8) begin
            $display("FAIL wait_len%0d: got %0d, required 8", i, (run_rd < run_wr) ? run_log[run_rd] : -1);
            n_fail++;
         end
         run_rd++;
      end
   endtask

   task automatic test_order_backpressure();
      core_mode = 1;
      core_lat  = 3;
      exp_core.push_back({1'b0, 24'h222222});
      exp_core.push_back({1'b1, 24'h111111});
      exp_l.push_back(24'hDDDDDD);
      exp_r.push_back(24'hEEEEEE);
      adc_push(1'b1, 24'h111111);
      n_checks++;
      if (adc_r_ready !== 1'b0 || adc_l_ready !== 1'b1) begin
         $display("FAIL order_ready: got l=%b r=%b, required 1 0", adc_l_ready, adc_r_ready);
         n_fail++;
      end
      adc_push(1'b0, 24'h222222);
      drain(0, 5);
      core_log_compare("order");
   endtask

   task automatic test_coincide_stale();
      int n;
      int seen0;
      seen0 = stale_ready_seen;
      stale_req = stale_req + 3;
      n = 0;
      while (stale_done < stale_req && n < 50) begin @(posedge clk); n++; end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (stale_done != stale_req || stale_ready_seen != seen0) begin
         $display("FAIL stale_ignored: got ready_seen=%0d done=%0d, required %0d %0d",
                  stale_ready_seen, stale_done, seen0, stale_req);
         n_fail++;
      end
      n_checks++;
      if (busy !== 1'b0 || timeout_count !== 16'd2) begin
         $display("FAIL stale_state: got busy=%b tc=%0d, required 0 2", busy, timeout_count);
         n_fail++;
      end
      core_mode = 1;
      core_lat  = 7;
      run_rd = run_wr;
      exp_core.push_back({1'b0, 24'h000001});
      exp_core.push_back({1'b1, 24'h800000});
      exp_l.push_back(24'hFFFFFE);
      exp_r.push_back(24'h7FFFFF);
      adc_push(1'b0, 24'h000001);
      adc_push(1'b1, 24'h800000);
      drain(0, 0);
      core_log_compare("coincide");
      n_checks++;
      if (timeout_count !== 16'd2) begin
         $display("FAIL coincide_timeout_count: got %0d, required 2", timeout_count);
         n_fail++;
      end
      n_checks++;
      if (run_rd >= run_wr || run_log[run_rd] != 8) begin
         $display("FAIL coincide_wait_len: got %0d, required 8", (run_rd < run_wr) ? run_log[run_rd] : -1);
         n_fail++;
      end
      run_rd = run_wr;
   endtask

   task automatic test_reset_mid();
      int base, n;
      core_mode = 0;
      base = obs_wr;
      adc_push(1'b0, 24'h333333);
      adc_push(1'b1, 24'h444444);
      n = 0;
      while (obs_wr < base + 2 && n < 100) begin @(posedge clk); n++; end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (core_out_ready !== 1'b1 || busy !== 1'b1 || timeout_count !== 16'd3) begin
         $display("FAIL pre_reset_wait_r: got ready=%b busy=%b tc=%0d, required 1 1 3",
                  core_out_ready, busy, timeout_count);
         n_fail++;
      end
      reset_n = 1'b0;
      #2;
      n_checks++;
      if ({dac_l_valid, dac_r_valid, core_in_valid, core_out_ready, busy} !== 5'b00000 || timeout_count !== 16'd0) begin
         $display("FAIL mid_reset: got valids=%b tc=%0d, required 00000 0",
                  {dac_l_valid, dac_r_valid, core_in_valid, core_out_ready, busy}, timeout_count);
         n_fail++;
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      obs_rd = obs_wr;
      run_rd = run_wr;
      exp_l.delete();
      exp_r.delete();
      exp_core.delete();
      core_mode = 1;
      core_lat  = 3;
      exp_core.push_back({1'b0, 24'h00FF00});
      exp_core.push_back({1'b1, 24'h0F0000});
      exp_l.push_back(24'hFF00FF);
      exp_r.push_back(24'hF0FFFF);
      adc_push(1'b0, 24'h00FF00);
      adc_push(1'b1, 24'h0F0000);
      drain(0, 0);
      core_log_compare("after_reset");
      n_checks++;
      if (timeout_count !== 16'd0) begin
         $display("FAIL after_reset_tc: got %0d, required 0", timeout_count);
         n_fail++;
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      adc_l_data    = 24'h0;
      adc_r_data    = 24'h0;
      adc_l_valid   = 1'b0;
      adc_r_valid   = 1'b0;
      dac_l_ready   = 1'b0;
      dac_r_ready   = 1'b0;
      core_in_ready = 1'b1;
      bypass        = 1'b0;
      test_reset();
      test_bypass();
      test_core_echo();
      test_timeout();
      test_order_backpressure();
      test_coincide_stale();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
